// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle for alu_op_sequencer.
// master = requester/consumer side, slave = the sequencer.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       aluop;
    logic [10:0]      opcode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_illegal;

    modport master (
        output in_valid, aluop, opcode, op_a, op_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_illegal
    );

    modport slave (
        input  in_valid, aluop, opcode, op_a, op_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_illegal
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Decodes LEGv8 ALUOp/opcode, drives an external 64-bit ALU and returns its result.
// Define ALU_SEQ_MUL_EN to add the iterative shift-add MUL sequencer.
module alu_op_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    alu_op_sequencer_if.slave req,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [3:0]        alu_control,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero
);
    localparam logic [3:0] CTL_AND   = 4'b0000;
    localparam logic [3:0] CTL_ORR   = 4'b0001;
    localparam logic [3:0] CTL_ADD   = 4'b0010;
    localparam logic [3:0] CTL_SUB   = 4'b0110;
    localparam logic [3:0] CTL_PASSB = 4'b0111;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
`endif

    state_t     state;
    logic [3:0] dec_code;
    logic       dec_illegal;

`ifdef ALU_SEQ_MUL_EN
    logic             dec_mul;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH-1:0] acc_n, mcand_n, mplier_n;

    always_comb begin
        acc_n    = mplier[0] ? alu_result : acc;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
    end
`endif

    always_comb begin
        dec_code    = CTL_ADD;
        dec_illegal = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        dec_mul     = 1'b0;
`endif
        case (req.aluop)
            2'b00: dec_code = CTL_ADD;
            2'b01: dec_code = CTL_PASSB;
            2'b10: begin
                case (req.opcode)
                    11'b10001011000: dec_code = CTL_ADD;
                    11'b11001011000: dec_code = CTL_SUB;
                    11'b10001010000: dec_code = CTL_AND;
                    11'b10101010000: dec_code = CTL_ORR;
`ifdef ALU_SEQ_MUL_EN
                    11'b10011011000: dec_mul  = 1'b1;
`endif
                    default:         dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            req.in_ready    <= 1'b0;
            req.out_valid   <= 1'b0;
            req.out_result  <= '0;
            req.out_zero    <= 1'b0;
            req.out_illegal <= 1'b0;
            alu_a           <= '0;
            alu_b           <= '0;
            alu_control     <= CTL_ADD;
`ifdef ALU_SEQ_MUL_EN
            acc             <= '0;
            mcand           <= '0;
            mplier          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    req.in_ready <= 1'b1;
                    if (req.in_valid && req.in_ready) begin
                        req.in_ready    <= 1'b0;
                        req.out_illegal <= dec_illegal;
                        if (dec_illegal) begin
                            req.out_result <= '0;
                            req.out_zero   <= 1'b1;
                            req.out_valid  <= 1'b1;
                            state          <= DONE;
`ifdef ALU_SEQ_MUL_EN
                        end else if (dec_mul) begin
                            // ALU inputs are registered, so preload them with the first step's acc/mcand
                            acc         <= '0;
                            mcand       <= req.op_a;
                            mplier      <= req.op_b;
                            alu_a       <= '0;
                            alu_b       <= req.op_a;
                            alu_control <= CTL_ADD;
                            state       <= MUL;
`endif
                        end else begin
                            alu_a       <= req.op_a;
                            alu_b       <= req.op_b;
                            alu_control <= dec_code;
                            state       <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    req.out_result <= alu_result;
                    req.out_zero   <= alu_zero;
                    req.out_valid  <= 1'b1;
                    alu_a          <= '0;
                    alu_b          <= '0;
                    alu_control    <= CTL_ADD;
                    state          <= DONE;
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    if (mplier_n == '0) begin
                        req.out_result <= acc_n;
                        req.out_zero   <= (acc_n == '0);
                        req.out_valid  <= 1'b1;
                        alu_a          <= '0;
                        alu_b          <= '0;
                        state          <= DONE;
                    end else begin
                        acc    <= acc_n;
                        mcand  <= mcand_n;
                        mplier <= mplier_n;
                        alu_a  <= acc_n;
                        alu_b  <= mcand_n;
                    end
                end
`endif
                DONE: begin
                    if (req.out_ready) begin
                        req.out_valid <= 1'b0;
                        req.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer with a behavioural ALU and reference model.
// Honours ALU_SEQ_MUL_EN in the same way as the design.
module tb_alu_op_sequencer;
    localparam int W = 64;
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(W)) bus ();

    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_control;
    logic         alu_zero;

    alu_op_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (bus),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
    );

    // Combinational LEGv8 ALU
    always_comb begin
        case (alu_control)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = alu_b;
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] aluop, input logic [10:0] opc,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] res, output logic ill,
                                  output logic is_mul, output logic [3:0] ctl, output int lat);
        int nbits;
        res = '0; ill = 1'b0; is_mul = 1'b0; ctl = 4'b0010; lat = 2;
        case (aluop)
            2'b00: res = a + b;
            2'b01: begin ctl = 4'b0111; res = b; end
            2'b10: begin
                if (opc == OPC_ADD) res = a + b;
                else if (opc == OPC_SUB) begin ctl = 4'b0110; res = a - b; end
                else if (opc == OPC_AND) begin ctl = 4'b0000; res = a & b; end
                else if (opc == OPC_ORR) begin ctl = 4'b0001; res = a | b; end
`ifdef ALU_SEQ_MUL_EN
                else if (opc == OPC_MUL) begin
                    is_mul = 1'b1;
                    res = a * b;
                    nbits = 0;
                    for (int i = 0; i < W; i++) if (b[i]) nbits = i + 1;
                    lat = 1 + ((nbits < 1) ? 1 : nbits);
                end
`endif
                else ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin res = '0; lat = 1; end
    endfunction

    task automatic run_req(input string tag, input logic [1:0] aluop, input logic [10:0] opc,
                           input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W-1:0] res;
        logic ill, is_mul;
        logic [3:0] ctl;
        int lat, t, seen;
        model(aluop, opc, a, b, res, ill, is_mul, ctl, lat);
        t = 0;
        while (!bus.in_ready && t < 20) begin @(posedge clk); #1; t++; end
        check({tag, ".in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.aluop = aluop; bus.opcode = opc; bus.op_a = a; bus.op_b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.aluop = 2'($urandom); bus.opcode = 11'($urandom);
        bus.op_a = {$urandom, $urandom}; bus.op_b = {$urandom, $urandom};
        if (ill) begin
            check({tag, ".ctl_idle"}, alu_control, 4'b0010);
            check({tag, ".a_idle"}, alu_a, 0);
        end else if (is_mul) begin
            check({tag, ".mul_ctl"}, alu_control, 4'b0010);
            check({tag, ".mul_b0"}, alu_b, a);
        end else begin
            check({tag, ".ctl"}, alu_control, ctl);
            check({tag, ".alu_a"}, alu_a, a);
            check({tag, ".alu_b"}, alu_b, b);
        end
        seen = 1;
        while (!bus.out_valid && seen < 200) begin @(posedge clk); #1; seen++; end
        check({tag, ".latency"}, W'(seen), W'(lat));
        check({tag, ".result"}, bus.out_result, res);
        check({tag, ".zero"}, bus.out_zero, (res == '0));
        check({tag, ".illegal"}, bus.out_illegal, ill);
        check({tag, ".busy"}, bus.in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1; bus.aluop = 2'b00; bus.op_a = {$urandom, $urandom};
            @(posedge clk); #1;
            check({tag, ".hold_res"}, bus.out_result, res);
            check({tag, ".hold_valid"}, bus.out_valid, 1);
            check({tag, ".hold_ready"}, bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        check({tag, ".release_valid"}, bus.out_valid, 0);
        check({tag, ".release_ready"}, bus.in_ready, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".in_ready"}, bus.in_ready, 0);
        check({tag, ".out_valid"}, bus.out_valid, 0);
        check({tag, ".out_result"}, bus.out_result, 0);
        check({tag, ".out_zero"}, bus.out_zero, 0);
        check({tag, ".out_illegal"}, bus.out_illegal, 0);
        check({tag, ".alu_a"}, alu_a, 0);
        check({tag, ".alu_b"}, alu_b, 0);
        check({tag, ".alu_control"}, alu_control, 4'b0010);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [10:0] ops [5];
        logic [W-1:0] a, b;
        logic [1:0] aluop;
        logic [10:0] opc;
        int k;
        ops[0] = OPC_ADD; ops[1] = OPC_SUB; ops[2] = OPC_AND; ops[3] = OPC_ORR; ops[4] = OPC_MUL;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.aluop = '0; bus.opcode = '0;
        bus.op_a = '0; bus.op_b = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        run_req("add5p7", 2'b10, OPC_ADD, 64'd5, 64'd7, 0);
        run_req("sub_eq", 2'b10, OPC_SUB, 64'h1234, 64'h1234, 0);
        run_req("cbz0", 2'b01, 11'd0, 64'hdead, 64'd0, 0);
        run_req("ldst", 2'b00, 11'h7ff, 64'hffff_ffff_ffff_fff0, 64'h20, 0);
        run_req("mul6x11", 2'b10, OPC_MUL, 64'd6, 64'd11, 0);
        run_req("mul3x0", 2'b10, OPC_MUL, 64'd3, 64'd0, 0);
        run_req("illegal11", 2'b11, OPC_ADD, 64'd1, 64'd2, 0);
        run_req("bp5", 2'b10, OPC_ORR, 64'h0f0f, 64'hf000, 5);

`ifdef ALU_SEQ_MUL_EN
        run_req("mul_top", 2'b10, OPC_MUL, 64'd3, 64'h8000_0000_0000_0000, 0);
        // Abort a long MUL in its 10th cycle
        bus.in_valid = 1'b1; bus.aluop = 2'b10; bus.opcode = OPC_MUL;
        bus.op_a = 64'd1; bus.op_b = 64'd1 << 40;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_values("abort");
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort.ready_after", bus.in_ready, 1);
        check("abort.no_valid", bus.out_valid, 0);
        run_req("add1p1", 2'b10, OPC_ADD, 64'd1, 64'd1, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 8);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) b = a;
            aluop = 2'b10;
            opc = 11'($urandom);
            case (k)
                0: aluop = 2'b00;
                1: aluop = 2'b01;
                2, 3, 4, 5: opc = ops[k-2];
                6: begin opc = OPC_MUL; b = b >> $urandom_range(0, 63); end
                7: aluop = 2'b11;
                default: ;
            endcase
            run_req("rand", aluop, opc, a, b, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
